router_reg_gen: RTL and testbench
=================================

ROUTER_REG_GEN -- requirements
Module: router_reg_gen

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the data byte width.
REQ-002 The block SHALL have parameter NUM_CH, default 3, meaning the number of valid destination channels; the address field is data_in[1:0].
REQ-003 The block SHALL have parameter CHK_MODE, default 0, meaning 0 = XOR parity and 1 = sum modulo 2^DW.
REQ-004 The block SHALL have parameter HOLD_DEPTH, default 2, meaning the number of entries in the fifo_full hold buffer (range 1..4).
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning the width of the error counter.
REQ-006 The block SHALL have these ports, clock and reset first:
- router_clock, in, 1: clock; all logic on its rising edge.
- resetn, in, 1: synchronous, active-low reset.
- pkt_valid, in, 1: source byte valid.
- data_in, in, DW: source byte.
- fifo_full, in, 1: selected output FIFO full.
- rst_int_reg, detect_add, ld_state, lfd_state, laf_state, full_state, in, 1 each: controller FSM state decodes, at most one high per cycle.
- dout, out, DW: byte to FIFO.
- dout_valid, out, 1: dout updated this cycle.
- parity_done, out, 1: packet parity byte captured.
- low_pkt_valid, out, 1: pkt_valid fell during load.
- err, out, 1: checksum mismatch.
- addr_err, out, 1: one-cycle pulse for an invalid header address.
- hold_ovf, out, 1: sticky hold-buffer overflow.
- err_count, out, CNT_W: saturating count of errored packets.

Function
REQ-007 On detect_add && pkt_valid && data_in[1:0] < NUM_CH, the block SHALL load hdr_reg <= data_in.
- If the address is >= NUM_CH, the block SHALL pulse addr_err for 1 cycle and leave hdr_reg unchanged.
REQ-008 In lfd_state, the block SHALL drive dout <= hdr_reg and dout_valid <= 1 on the next edge.
REQ-009 In ld_state && !fifo_full, the block SHALL drive dout <= data_in and dout_valid <= 1.
REQ-010 In ld_state && fifo_full, the block SHALL push data_in into the hold buffer and hold dout unchanged.
- If the hold buffer is full, the block SHALL drop the byte and set hold_ovf.
REQ-011 In laf_state with the hold buffer non-empty, the block SHALL pop one entry per cycle to dout with dout_valid <= 1.
- An empty pop SHALL hold dout and drive dout_valid <= 0.
REQ-012 In every other case, dout_valid SHALL be 0 one cycle later; latency is 1 clock for every path.
REQ-013 The running checksum chk SHALL clear on detect_add.
- It SHALL fold hdr_reg in lfd_state.
- It SHALL fold data_in in ld_state && pkt_valid && !full_state.
- The fold SHALL be XOR or truncated add according to CHK_MODE.
REQ-014 On (ld_state && !pkt_valid && !fifo_full) || (laf_state && low_pkt_valid && !parity_done), pkt_parity SHALL capture all DW bits of data_in and parity_done SHALL set.
REQ-015 parity_done and pkt_parity SHALL clear on detect_add; the set condition wins on a simultaneous set and clear.
REQ-016 low_pkt_valid SHALL set on ld_state && !pkt_valid, otherwise clear on rst_int_reg, otherwise hold.
REQ-017 err SHALL be a registered output.
- err SHALL be 1 when parity_done && pkt_parity != chk.
- err SHALL be 0 whenever parity_done is 0.
REQ-018 err_count SHALL increment on each 0->1 transition of err and saturate at all-ones.
REQ-019 hold_ovf and the hold buffer contents SHALL clear on detect_add.

Reset
REQ-020 On resetn == 0 at a clock edge, every register SHALL clear in the same cycle:
- dout, hdr_reg, chk, pkt_parity, err_count = 0.
- dout_valid, parity_done, low_pkt_valid, err, addr_err, hold_ovf = 0.
- The hold buffer SHALL be emptied.
REQ-021 Reset asserted mid-packet SHALL discard all packet state, and no output SHALL pulse in the cycle after reset release.

Structure
REQ-022 A shared package router_pkg SHALL hold the CHK_XOR/CHK_SUM constants and the checksum fold function, for reuse by router_fifo checks.
REQ-023 The hold buffer SHALL be a sub-module router_hold_buf with push, pop, full, empty and clear ports, parameterised by DW and HOLD_DEPTH.

Verification
REQ-024 The bench SHALL cover XOR-mode checksum match: header 8'h09, payload 8'hF0 and 8'h20, parity 8'hD9 -> dout sequence 09,F0,20, parity_done = 1, err = 0.
REQ-025 The bench SHALL cover XOR-mode checksum mismatch: the same packet with parity 8'hD8 -> err = 1 one cycle after parity_done, err_count = 1.
REQ-026 The bench SHALL cover sum mode: CHK_MODE = 1, header 8'h09, payload 8'hF0 and 8'h20, parity 8'h19 -> err = 0; with parity 8'hD9 -> err = 1.
REQ-027 The bench SHALL cover an invalid address: detect_add with data_in 8'h07 and NUM_CH = 3 -> addr_err pulses 1 cycle and hdr_reg holds its previous value.
REQ-028 The bench SHALL cover the hold buffer: HOLD_DEPTH = 2, fifo_full during bytes AA, BB, CC -> hold_ovf = 1, then two laf_state cycles give dout AA then BB with dout_valid = 1.
REQ-029 The bench SHALL cover reset mid-payload after 2 bytes -> all outputs 0 on the next edge, and the following packet checks correctly with err_count unchanged from 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants and the checksum fold used by the register generator
// and by the router FIFO checks.
package router_pkg;

    localparam int CHK_XOR  = 0;
    localparam int CHK_SUM  = 1;
    localparam int CHK_MAXW = 32;

    // Callers zero-extend into CHK_MAXW and truncate the result back to their width.
    function automatic logic [CHK_MAXW-1:0] chk_fold(
        input logic [CHK_MAXW-1:0] acc,
        input logic [CHK_MAXW-1:0] b,
        input int                  mode
    );
        return (mode == CHK_SUM) ? (acc + b) : (acc ^ b);
    endfunction

endpackage

// File: rtl/router_hold_buf.sv
// Small circular buffer that parks payload bytes while the selected output FIFO
// is full; pop_data always shows the oldest entry.
module router_hold_buf #(
    parameter int DW         = 8,
    parameter int HOLD_DEPTH = 2
) (
    input  logic          router_clock,
    input  logic          resetn,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CW = $clog2(HOLD_DEPTH + 1);

    logic [DW-1:0] mem_q [HOLD_DEPTH];
    logic [DW-1:0] mem_d [HOLD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(HOLD_DEPTH - 1)) ? '0 : (p + PW'(1));
    endfunction

    assign full     = (count_q == CW'(HOLD_DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            mem_d    = '{default: '0};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge router_clock) begin
        if (!resetn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_reg_gen.sv
// Router register generator: header capture, byte steering to the output FIFO,
// running checksum against the trailing parity byte, and error accounting.
module router_reg_gen
    import router_pkg::*;
#(
    parameter int DW         = 8,
    parameter int NUM_CH     = 3,
    parameter int CHK_MODE   = 0,
    parameter int HOLD_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             router_clock,
    input  logic             resetn,
    input  logic             pkt_valid,
    input  logic [DW-1:0]    data_in,
    input  logic             fifo_full,
    input  logic             rst_int_reg,
    input  logic             detect_add,
    input  logic             ld_state,
    input  logic             lfd_state,
    input  logic             laf_state,
    input  logic             full_state,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err,
    output logic             addr_err,
    output logic             hold_ovf,
    output logic [CNT_W-1:0] err_count
);

    logic [DW-1:0]    hdr_q, hdr_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic [DW-1:0]    chk_q, chk_d;
    logic [DW-1:0]    pkt_parity_q, pkt_parity_d;
    logic             dout_valid_q, dout_valid_d;
    logic             parity_done_q, parity_done_d;
    logic             low_pkt_valid_q, low_pkt_valid_d;
    logic             err_q, err_d;
    logic             addr_err_q, addr_err_d;
    logic             hold_ovf_q, hold_ovf_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             addr_ok, par_set;
    logic [DW-1:0]    buf_data;
    logic             buf_full, buf_empty;

    router_hold_buf #(
        .DW         (DW),
        .HOLD_DEPTH (HOLD_DEPTH)
    ) u_hold_buf (
        .router_clock (router_clock),
        .resetn       (resetn),
        .clear        (detect_add),
        .push         (ld_state && fifo_full),
        .push_data    (data_in),
        .pop          (laf_state),
        .pop_data     (buf_data),
        .full         (buf_full),
        .empty        (buf_empty)
    );

    assign addr_ok = int'(data_in[1:0]) < NUM_CH;
    // The second term recovers a parity byte that arrived while the FIFO was full.
    assign par_set = (ld_state && !pkt_valid && !fifo_full) ||
                     (laf_state && low_pkt_valid_q && !parity_done_q);

    always_comb begin
        hdr_d           = hdr_q;
        dout_d          = dout_q;
        dout_valid_d    = 1'b0;
        chk_d           = chk_q;
        pkt_parity_d    = pkt_parity_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
        addr_err_d      = 1'b0;
        hold_ovf_d      = hold_ovf_q;
        err_count_d     = err_count_q;

        if (detect_add && pkt_valid) begin
            if (addr_ok) begin
                hdr_d = data_in;
            end else begin
                addr_err_d = 1'b1;
            end
        end

        if (lfd_state) begin
            dout_d       = hdr_q;
            dout_valid_d = 1'b1;
        end else if (ld_state && !fifo_full) begin
            dout_d       = data_in;
            dout_valid_d = 1'b1;
        end else if (laf_state && !buf_empty) begin
            dout_d       = buf_data;
            dout_valid_d = 1'b1;
        end

        if (detect_add) begin
            hold_ovf_d = 1'b0;
        end else if (ld_state && fifo_full && buf_full) begin
            hold_ovf_d = 1'b1;
        end

        if (detect_add) begin
            chk_d = '0;
        end else if (lfd_state) begin
            chk_d = DW'(chk_fold(CHK_MAXW'(chk_q), CHK_MAXW'(hdr_q), CHK_MODE));
        end else if (ld_state && pkt_valid && !full_state) begin
            chk_d = DW'(chk_fold(CHK_MAXW'(chk_q), CHK_MAXW'(data_in), CHK_MODE));
        end

        if (par_set) begin
            pkt_parity_d  = data_in;
            parity_done_d = 1'b1;
        end else if (detect_add) begin
            pkt_parity_d  = '0;
            parity_done_d = 1'b0;
        end

        if (ld_state && !pkt_valid) begin
            low_pkt_valid_d = 1'b1;
        end else if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
        end

        err_d = parity_done_q && (pkt_parity_q != chk_q);
        if (err_d && !err_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge router_clock) begin
        if (!resetn) begin
            hdr_q           <= '0;
            dout_q          <= '0;
            dout_valid_q    <= 1'b0;
            chk_q           <= '0;
            pkt_parity_q    <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
            err_q           <= 1'b0;
            addr_err_q      <= 1'b0;
            hold_ovf_q      <= 1'b0;
            err_count_q     <= '0;
        end else begin
            hdr_q           <= hdr_d;
            dout_q          <= dout_d;
            dout_valid_q    <= dout_valid_d;
            chk_q           <= chk_d;
            pkt_parity_q    <= pkt_parity_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
            err_q           <= err_d;
            addr_err_q      <= addr_err_d;
            hold_ovf_q      <= hold_ovf_d;
            err_count_q     <= err_count_d;
        end
    end

    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
    assign err           = err_q;
    assign addr_err      = addr_err_q;
    assign hold_ovf      = hold_ovf_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_router_reg_gen.sv
// Bench for router_reg_gen: an XOR-mode and a sum-mode instance share stimulus and
// are checked every cycle against a queue-based packet model plus fixed expectations.
module tb_router_reg_gen;

    localparam int DW         = 8;
    localparam int NUM_CH     = 3;
    localparam int HOLD_DEPTH = 2;
    localparam int CNT_W      = 8;

    logic       router_clock = 1'b0;
    logic       resetn       = 1'b0;
    logic       pkt_valid    = 1'b0;
    logic [7:0] data_in      = 8'h00;
    logic       fifo_full    = 1'b0;
    logic       rst_int_reg  = 1'b0;
    logic       detect_add   = 1'b0;
    logic       ld_state     = 1'b0;
    logic       lfd_state    = 1'b0;
    logic       laf_state    = 1'b0;
    logic       full_state   = 1'b0;

    logic [7:0] dout          [2];
    logic       dout_valid    [2];
    logic       parity_done   [2];
    logic       low_pkt_valid [2];
    logic       err           [2];
    logic       addr_err      [2];
    logic       hold_ovf      [2];
    logic [7:0] err_count     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        router_reg_gen #(
            .DW(DW), .NUM_CH(NUM_CH), .CHK_MODE(g), .HOLD_DEPTH(HOLD_DEPTH), .CNT_W(CNT_W)
        ) dut (
            .router_clock  (router_clock),
            .resetn        (resetn),
            .pkt_valid     (pkt_valid),
            .data_in       (data_in),
            .fifo_full     (fifo_full),
            .rst_int_reg   (rst_int_reg),
            .detect_add    (detect_add),
            .ld_state      (ld_state),
            .lfd_state     (lfd_state),
            .laf_state     (laf_state),
            .full_state    (full_state),
            .dout          (dout[g]),
            .dout_valid    (dout_valid[g]),
            .parity_done   (parity_done[g]),
            .low_pkt_valid (low_pkt_valid[g]),
            .err           (err[g]),
            .addr_err      (addr_err[g]),
            .hold_ovf      (hold_ovf[g]),
            .err_count     (err_count[g])
        );
    end

    always #5 router_clock = ~router_clock;

    int total = 0;
    int bad   = 0;

    // Packet-level model: one set of shared outputs, per-mode checksum and error state.
    logic [7:0] m_hdr, m_dout, m_par;
    bit         m_dv, m_pdone, m_lpv, m_aerr, m_ovf;
    logic [7:0] m_chk [2];
    bit         m_err [2];
    int         m_cnt [2];
    logic [7:0] m_hold [$];
    logic [7:0] seen [$];

    logic [7:0] r_hdr, r_par;
    int         r_len;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] fold(input int mode, input logic [7:0] a, input logic [7:0] b);
        return (mode == 1) ? 8'(a + b) : (a ^ b);
    endfunction

    task automatic model_edge();
        bit par_set, e;
        if (!resetn) begin
            m_hdr = 0; m_dout = 0; m_par = 0;
            m_dv = 0; m_pdone = 0; m_lpv = 0; m_aerr = 0; m_ovf = 0;
            m_hold.delete();
            for (int m = 0; m < 2; m++) begin
                m_chk[m] = 0; m_err[m] = 0; m_cnt[m] = 0;
            end
            return;
        end
        for (int m = 0; m < 2; m++) begin
            e = m_pdone && (m_par != m_chk[m]);
            if (e && !m_err[m] && m_cnt[m] < 255) m_cnt[m]++;
            m_err[m] = e;
        end
        par_set = (ld_state && !pkt_valid && !fifo_full) || (laf_state && m_lpv && !m_pdone);
        m_aerr  = detect_add && pkt_valid && ((data_in % 4) >= NUM_CH);
        m_dv    = 0;
        if (lfd_state) begin
            m_dout = m_hdr; m_dv = 1;
        end else if (ld_state && !fifo_full) begin
            m_dout = data_in; m_dv = 1;
        end else if (ld_state) begin
            if (m_hold.size() < HOLD_DEPTH) m_hold.push_back(data_in);
            else m_ovf = 1;
        end else if (laf_state && m_hold.size() != 0) begin
            m_dout = m_hold.pop_front(); m_dv = 1;
        end
        for (int m = 0; m < 2; m++) begin
            if (detect_add) m_chk[m] = 0;
            else if (lfd_state) m_chk[m] = fold(m, m_chk[m], m_hdr);
            else if (ld_state && pkt_valid && !full_state) m_chk[m] = fold(m, m_chk[m], data_in);
        end
        if (detect_add && pkt_valid && ((data_in % 4) < NUM_CH)) m_hdr = data_in;
        if (detect_add) begin
            m_hold.delete(); m_ovf = 0;
        end
        if (par_set) begin
            m_par = data_in; m_pdone = 1;
        end else if (detect_add) begin
            m_par = 0; m_pdone = 0;
        end
        if (ld_state && !pkt_valid) m_lpv = 1;
        else if (rst_int_reg) m_lpv = 0;
    endtask

    task automatic compare();
        for (int g = 0; g < 2; g++) begin
            check("dout",          g, dout[g],          m_dout);
            check("dout_valid",    g, dout_valid[g],    m_dv);
            check("parity_done",   g, parity_done[g],   m_pdone);
            check("low_pkt_valid", g, low_pkt_valid[g], m_lpv);
            check("addr_err",      g, addr_err[g],      m_aerr);
            check("hold_ovf",      g, hold_ovf[g],      m_ovf);
            check("err",           g, err[g],           m_err[g]);
            check("err_count",     g, err_count[g],     m_cnt[g]);
        end
        if (dout_valid[0]) seen.push_back(dout[0]);
    endtask

    task automatic tick();
        @(posedge router_clock);
        model_edge();
        @(negedge router_clock);
        compare();
    endtask

    task automatic cyc(input bit det, input bit lfd, input bit ld, input bit laf, input bit fst,
                       input bit rint, input bit pv, input bit ff, input logic [7:0] din);
        detect_add = det; lfd_state = lfd; ld_state = ld; laf_state = laf;
        full_state = fst; rst_int_reg = rint; pkt_valid = pv; fifo_full = ff; data_in = din;
        tick();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    // Header, two payload bytes, parity; returns right after the parity edge.
    task automatic pkt2(input logic [7:0] h, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] par);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, h);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, p0);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, p0);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, p1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, par);
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_dout"},      g, dout[g],          0);
            check({tag, "_dv"},        g, dout_valid[g],    0);
            check({tag, "_pdone"},     g, parity_done[g],   0);
            check({tag, "_lpv"},       g, low_pkt_valid[g], 0);
            check({tag, "_err"},       g, err[g],           0);
            check({tag, "_addr_err"},  g, addr_err[g],      0);
            check({tag, "_hold_ovf"},  g, hold_ovf[g],      0);
            check({tag, "_err_count"}, g, err_count[g],     0);
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        idle();
        check_all_zero("reset");
        resetn = 1'b1;
        idle();

        // XOR match; the sum-mode instance sees D9 against 0x19 and flags it.
        seen.delete();
        pkt2(8'h09, 8'hF0, 8'h20, 8'hD9);
        check("xor_match_pdone", 0, parity_done[0], 1);
        idle();
        check("xor_match_err", 0, err[0], 0);
        check("sum_d9_err",    1, err[1], 1);
        check("seen_len", 0, (seen.size() >= 3) ? 1 : 0, 1);
        if (seen.size() >= 3) begin
            check("seen0", 0, seen[0], 8'h09);
            check("seen1", 0, seen[1], 8'hF0);
            check("seen2", 0, seen[2], 8'h20);
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        // XOR mismatch: err follows parity_done by one cycle.
        pkt2(8'h09, 8'hF0, 8'h20, 8'hD8);
        check("xor_mis_pdone", 0, parity_done[0], 1);
        check("xor_mis_err_early", 0, err[0], 0);
        idle();
        check("xor_mis_err", 0, err[0], 1);
        check("xor_mis_cnt", 0, err_count[0], 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        // Sum-mode match.
        pkt2(8'h09, 8'hF0, 8'h20, 8'h19);
        idle();
        check("sum_match_err", 1, err[1], 0);
        check("sum_match_cnt", 1, err_count[1], 2);
        check("xor_19_err",    0, err[0], 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        // Invalid address leaves the header at 09.
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h07);
        check("addr_err_pulse", 0, addr_err[0], 1);
        idle();
        check("addr_err_drop", 0, addr_err[0], 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'h55);
        check("hdr_kept", 0, dout[0], 8'h09);
        check("hdr_kept_dv", 0, dout_valid[0], 1);

        // Hold buffer overflow and drain.
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h01);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'hAA);
        cyc(0, 0, 1, 0, 0, 0, 1, 1, 8'hAA);
        cyc(0, 0, 1, 0, 0, 0, 1, 1, 8'hBB);
        cyc(0, 0, 1, 0, 0, 0, 1, 1, 8'hCC);
        check("hold_ovf_set", 0, hold_ovf[0], 1);
        check("hold_dv_low",  0, dout_valid[0], 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        check("drain0", 0, dout[0], 8'hAA);
        check("drain0_dv", 0, dout_valid[0], 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        check("drain1", 0, dout[0], 8'hBB);
        check("drain1_dv", 0, dout_valid[0], 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
        check("drain_empty_dv", 0, dout_valid[0], 0);
        check("drain_empty_dout", 0, dout[0], 8'hBB);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        // Reset in mid-payload, with ld_state still asserted.
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h09);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'hF0);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'hF0);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'h20);
        resetn = 1'b0;
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'h33);
        check_all_zero("midrst");
        resetn = 1'b1;
        idle();
        check_all_zero("release");
        pkt2(8'h09, 8'hF0, 8'h20, 8'hD9);
        idle();
        check("post_rst_pdone", 0, parity_done[0], 1);
        check("post_rst_err",   0, err[0], 0);
        check("post_rst_cnt",   0, err_count[0], 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);

        // Randomized packets.
        for (int k = 0; k < 150; k++) begin
            r_hdr = 8'($urandom);
            r_len = $urandom_range(1, 6);
            cyc(1, 0, 0, 0, 0, 0, 1, 0, r_hdr);
            cyc(0, 1, 0, 0, 0, 0, 1, 0, 8'($urandom));
            for (int i = 0; i < r_len; i++)
                cyc(0, 0, 1, 0, 0, 0, 1, ($urandom_range(0, 3) == 0), 8'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                resetn = 1'b0;
                cyc(0, 0, 1, 0, 0, 0, 1, 0, 8'($urandom));
                resetn = 1'b1;
                idle();
                continue;
            end
            r_par = ($urandom_range(0, 1) == 1) ? m_chk[$urandom_range(0, 1)] : 8'($urandom);
            cyc(0, 0, 1, 0, 0, 0, 0, ($urandom_range(0, 3) == 0), r_par);
            repeat ($urandom_range(0, 3)) cyc(0, 0, 0, 1, 0, 0, 0, 0, 8'($urandom));
            if ($urandom_range(0, 4) == 0) cyc(0, 0, 0, 0, 1, 0, 1, 1, 8'($urandom));
            cyc(0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
            repeat ($urandom_range(0, 2)) idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
